// File: rtl/ad9833_pkg.sv
// Shared definitions for the AD9833 serial receiver: word types, control bits, FSM states.
package ad9833_pkg;

  typedef enum logic [1:0] {
    WT_CTRL  = 2'b00,
    WT_FREQ0 = 2'b01,
    WT_FREQ1 = 2'b10,
    WT_PHASE = 2'b11
  } word_type_e;

  localparam int unsigned CTRL_B28   = 13;
  localparam int unsigned CTRL_HLB   = 12;
  localparam int unsigned CTRL_RESET = 8;

  localparam logic [15:0] CTRL_RESET_VAL = 16'h0100;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_e;

  // Replace either the MSB or the LSB 14-bit half of a 28-bit frequency shadow.
  function automatic logic [27:0] freq_load(input logic [27:0] cur,
                                            input logic [13:0] data,
                                            input logic        msb);
    return msb ? {data, cur[13:0]} : {cur[27:14], data};
  endfunction

endpackage

// File: rtl/ad9833_rx_sync.sv
// Multi-bit flop-chain synchronizer; bit 0 is treated as sclk and edge-detected.
module ad9833_rx_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_sclk_rise,
  output logic             o_sclk_fall
);
  import ad9833_pkg::*;

  logic [WIDTH-1:0] r_chain [STAGES];
  logic             r_sclk_prev;

  // Chain resets low so an fsync already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) r_chain[i] <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_chain[0] <= i_async;
      for (int unsigned i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_sclk_prev <= r_chain[STAGES-1][0];
    end
  end

  assign o_sync      = r_chain[STAGES-1];
  assign o_sclk_rise =  o_sync[0] & ~r_sclk_prev;
  assign o_sclk_fall = ~o_sync[0] &  r_sclk_prev;

endmodule

// File: rtl/ad9833_rx.sv
// AD9833 3-wire bus receiver: assembles 16-bit frames and shadows the device register file.
module ad9833_rx #(
  parameter int unsigned SAMPLE_ON_RISE = 1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fsync,
  input  logic        sclk,
  input  logic        sdata,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic [15:0] ctrl_reg,
  output logic [27:0] freq0,
  output logic [27:0] freq1,
  output logic [11:0] phase0,
  output logic [11:0] phase1,
  output logic        frame_err,
  input  logic        clr_err
);
  import ad9833_pkg::*;

  logic [2:0]  w_sync;
  logic        w_rise, w_fall, w_edge, w_fsync, w_sdata, w_fsync_fall, w_err_set;
  logic [15:0] w_word;
  rx_state_e   r_state, w_next;
  logic        r_fsync_prev;
  logic [3:0]  r_bit_cnt;
  logic [14:0] r_shift;
  logic        r_tog0, r_tog1;
  logic        r_word_valid, r_frame_err;
  logic [15:0] r_word_data, r_ctrl;
  logic [27:0] r_freq0, r_freq1;
  logic [11:0] r_phase0, r_phase1;

  ad9833_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_async     ({sdata, fsync, sclk}),
    .o_sync      (w_sync),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall)
  );

  assign w_fsync      = w_sync[1];
  assign w_sdata      = w_sync[2];
  assign w_edge       = (SAMPLE_ON_RISE != 0) ? w_rise : w_fall;
  assign w_fsync_fall = r_fsync_prev & ~w_fsync;
  assign w_err_set    = (r_state == ST_SHIFT) && w_fsync && (r_bit_cnt != 4'd0);
  assign w_word       = {r_shift, w_sdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fsync_fall) w_next = ST_SHIFT;
      ST_SHIFT: if (w_fsync)      w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsync_prev <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tog0       <= 1'b0;
      r_tog1       <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_ctrl       <= CTRL_RESET_VAL;
      r_freq0      <= '0;
      r_freq1      <= '0;
      r_phase0     <= '0;
      r_phase1     <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_fsync_prev <= w_fsync;
      r_word_valid <= 1'b0;
      if (w_err_set)    r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;

      // An sclk edge coinciding with the fsync rise is dropped along with any partial word.
      if (r_state != ST_SHIFT || w_fsync) begin
        r_bit_cnt <= '0;
      end else if (w_edge) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= w_word[14:0];
        if (r_bit_cnt == 4'd15) begin
          r_word_valid <= 1'b1;
          r_word_data  <= w_word;
          case (word_type_e'(w_word[15:14]))
            WT_CTRL: begin
              r_ctrl <= w_word;
              r_tog0 <= 1'b0;
              r_tog1 <= 1'b0;
            end
            WT_FREQ0: begin
              r_freq0 <= freq_load(r_freq0, w_word[13:0],
                                   r_ctrl[CTRL_B28] ? r_tog0 : r_ctrl[CTRL_HLB]);
              r_tog0  <= r_ctrl[CTRL_B28] & ~r_tog0;
            end
            WT_FREQ1: begin
              r_freq1 <= freq_load(r_freq1, w_word[13:0],
                                   r_ctrl[CTRL_B28] ? r_tog1 : r_ctrl[CTRL_HLB]);
              r_tog1  <= r_ctrl[CTRL_B28] & ~r_tog1;
            end
            default: begin
              if (w_word[13]) r_phase1 <= w_word[11:0];
              else            r_phase0 <= w_word[11:0];
            end
          endcase
        end
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign ctrl_reg   = r_ctrl;
  assign freq0      = r_freq0;
  assign freq1      = r_freq1;
  assign phase0     = r_phase0;
  assign phase1     = r_phase1;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ad9833_rx.sv
// Scoreboard bench for ad9833_rx: directed frames, expected words queued, monitor checks word_valid.
module tb_ad9833_rx;

  logic        clk = 1'b0;
  logic        rst_n, fsync, sclk, sdata, clr_err;
  logic        word_valid, frame_err;
  logic [15:0] word_data, ctrl_reg;
  logic [27:0] freq0, freq1;
  logic [11:0] phase0, phase1;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  ad9833_rx #(.SAMPLE_ON_RISE(1), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsync      (fsync),
    .sclk       (sclk),
    .sdata      (sdata),
    .word_valid (word_valid),
    .word_data  (word_data),
    .ctrl_reg   (ctrl_reg),
    .freq0      (freq0),
    .freq1      (freq1),
    .phase0     (phase0),
    .phase1     (phase1),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && word_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", word_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (word_data !== e) begin
          errors++;
          $display("FAIL word_data: got 0x%0h expected 0x%0h", word_data, e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sclk  = 1'b0;
      sdata = w[i];
      cycles(4);
      sclk = 1'b1;
      cycles(4);
    end
  endtask

  task automatic frame_start();
    sclk  = 1'b0;
    fsync = 1'b0;
    cycles(4);
  endtask

  task automatic frame_end();
    sclk = 1'b0;
    cycles(4);
    fsync = 1'b1;
    cycles(8);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL word_timeout: got %0d pending words expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1, input bit two);
    frame_start();
    exp_q.push_back(w0);
    send_bits(w0, 15, 0);
    if (two) begin
      exp_q.push_back(w1);
      send_bits(w1, 15, 0);
    end
    frame_end();
    wait_drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  {31'd0, word_valid}, 32'd0);
    chk({tag, "_data"},   {16'd0, word_data},  32'h0);
    chk({tag, "_ctrl"},   {16'd0, ctrl_reg},   32'h0100);
    chk({tag, "_freq0"},  {4'd0, freq0},       32'h0);
    chk({tag, "_freq1"},  {4'd0, freq1},       32'h0);
    chk({tag, "_phase0"}, {20'd0, phase0},     32'h0);
    chk({tag, "_phase1"}, {20'd0, phase1},     32'h0);
    chk({tag, "_err"},    {31'd0, frame_err},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fsync = 1'b1; sclk = 1'b0; sdata = 1'b0; clr_err = 1'b0;
    cycles(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cycles(5);

    send_frame(16'h2100, 16'h0, 1'b0);
    chk("ctrl_2100", {16'd0, ctrl_reg}, 32'h2100);
    chk("err_clean", {31'd0, frame_err}, 32'd0);

    send_frame(16'h50C7, 16'h4000, 1'b1);
    chk("freq0_b28", {4'd0, freq0}, 32'h00010C7);
    chk("freq1_untouched", {4'd0, freq1}, 32'h0);

    send_frame(16'h1000, 16'h8ABC, 1'b1);
    chk("freq1_hlb_msb", {4'd0, freq1}, 32'h2AF0000);
    send_frame(16'h0000, 16'h8123, 1'b1);
    chk("freq1_hlb_lsb", {4'd0, freq1}, 32'h2AF0123);

    send_frame(16'hC555, 16'hE7FF, 1'b1);
    chk("phase0", {20'd0, phase0}, 32'h555);
    chk("phase1", {20'd0, phase1}, 32'h7FF);

    // Partial 9-bit frame: no word, sticky error.
    frame_start();
    send_bits(16'hC0AA, 15, 7);
    frame_end();
    chk("err_partial", {31'd0, frame_err}, 32'd1);
    chk("phase0_kept", {20'd0, phase0}, 32'h555);

    send_frame(16'hC123, 16'h0, 1'b0);
    chk("phase0_after_err", {20'd0, phase0}, 32'h123);
    chk("err_sticky", {31'd0, frame_err}, 32'd1);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
    chk("err_cleared", {31'd0, frame_err}, 32'd0);

    // Reset after 7 bits; the rest of that frame must be ignored.
    frame_start();
    send_bits(16'h5ABC, 15, 9);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cycles(2);
    rst_n = 1'b1;
    send_bits(16'h5ABC, 8, 0);
    frame_end();
    chk("err_after_rst", {31'd0, frame_err}, 32'd0);
    chk("freq0_after_rst", {4'd0, freq0}, 32'h0);

    send_frame(16'h4ABC, 16'h0, 1'b0);
    chk("freq0_post_rst", {4'd0, freq0}, 32'h0000ABC);
    chk("ctrl_post_rst", {16'd0, ctrl_reg}, 32'h0100);

    cycles(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9833_rx.md
Name: ad9833_rx

Overview:
- Serial-interface receiver for the AD9833 3-wire bus (fsync, sclk, sdata). It is the listening end of our AD9833 writer.
- Oversamples the bus in the system clock domain and assembles 16-bit MSB-first words while fsync is low.
- Decodes each word into a shadow of the AD9833 register file: control, FREQ0/1 (28-bit) and PHASE0/1 (12-bit).
- Used as a bench checker and as a synthesizable loopback monitor.

Parameters:
- SAMPLE_ON_RISE, 1, 1 = capture sdata on the sclk rising edge (our writer changes sdata on sclk fall); 0 = capture on the falling edge, per the datasheet.
- SYNC_STAGES, 2, synchronizer depth on sclk/fsync/sdata; legal range 2..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fsync  in  1  frame select, active low
- sclk  in  1  serial clock
- sdata  in  1  serial data
- word_valid  out  1  one-cycle pulse: a complete 16-bit word was received
- word_data  out  16  last complete word; held until the next word
- ctrl_reg  out  16  last control word (bits 15:14 = 00)
- freq0  out  28  FREQ0 register shadow
- freq1  out  28  FREQ1 register shadow
- phase0  out  12  PHASE0 register shadow
- phase1  out  12  PHASE1 register shadow
- frame_err  out  1  sticky: fsync rose with a partial word (1..15 bits)
- clr_err  in  1  synchronous clear of frame_err

Behaviour:
- Clock and reset:
  - Reset is asynchronous, active-low.
  - All outputs reset to 0, except ctrl_reg, which resets to 0x0100 (RESET bit set, as at device power-up).
  - The bit counter and shift register reset to 0.
- Synchronization:
  - sclk, fsync and sdata each pass through SYNC_STAGES flops.
  - Edge detection is done on the synchronized sclk against its previous value.
  - Requirement: sclk high and low phases are each at least 3 clk cycles.
- States:
  - IDLE: synced fsync high. Bit counter held at 0.
  - SHIFT: entered when synced fsync falls.
  - On each selected sclk edge in SHIFT, shift sdata into bit 0 and increment bit_cnt (4 bits).
  - When bit_cnt wraps from 15 to 0:
    - word_data takes the full word.
    - word_valid pulses in the cycle after the edge that captured bit 0, so latency is SYNC_STAGES+1 clk from that sclk edge.
    - Decode runs in the same cycle.
  - Further words in the same frame continue without leaving SHIFT.
  - fsync rising in SHIFT returns to IDLE:
    - bit_cnt != 0: set frame_err, discard the partial word.
    - bit_cnt == 0: clean exit.
- Edge cases:
  - sclk edge in the same cycle as the fsync rise: ignored.
  - fsync falls while sclk is already low/high: no capture until the first selected edge after the fall.
  - clr_err and a new error in the same cycle: the error wins.
- Decode (on each completed word w):
  - w[15:14]=00 → ctrl_reg ← w.
  - w[15:14]=01 → FREQ0 write; w[15:14]=10 → FREQ1 write. Data = w[13:0].
    - ctrl_reg[13] (B28) = 1: the first write loads the LSB 14 bits and arms a per-register toggle; the second loads the MSB 14 bits and clears the toggle.
    - B28 = 0: ctrl_reg[12] (HLB) selects MSB (1) or LSB (0) 14 bits. The toggle is cleared.
    - Any control-word write clears both toggles.
  - w[15:14]=11 → w[13] selects PHASE1 (1) or PHASE0 (0); phaseN ← w[11:0]. w[12] is ignored.
  - A control word and a freq write never coincide (one word per cycle max).
- Reset mid-frame: everything returns to reset values, FSM to IDLE. After reset, a frame already in progress (synced fsync low) is ignored until fsync goes high and then low again.

Decomposition:
- Shared package ad9833_pkg:
  - word-type encoding (CTRL=2'b00, FREQ0=2'b01, FREQ1=2'b10, PHASE=2'b11)
  - ctrl bit indices (B28=13, HLB=12, RESET=8)
  - reset value for ctrl_reg
  - FSM state enum
- One sub-module, ad9833_rx_sync: a parameterized multi-bit synchronizer plus sclk edge detector, outputs sclk_rise/sclk_fall pulses.
- Decode stays in ad9833_rx.

Test Plan:
- Single control word 0x2100 in one frame → word_valid pulses once, word_data=0x2100, ctrl_reg=0x2100, frame_err=0.
- B28=1 then words 0x50C7, 0x4000 in one frame → freq0=0x00010C7 after the 2nd word; freq1 unchanged at 0.
- Control 0x1000 (B28=0, HLB=1), then 0x8ABC → freq1[27:14]=0x0ABC and freq1[13:0] unchanged; then control 0x0000 and 0x8123 → freq1[13:0]=0x0123.
- Phase words 0xC555 then 0xE7FF → phase0=0x555, phase1=0x7FF.
- fsync raised after 9 bits → no word_valid, frame_err=1. Next clean frame still decodes correctly. clr_err → frame_err=0.
- rst_n asserted mid-word (bit 7) → all outputs at reset values immediately, ctrl_reg=0x0100. The remaining bits of that frame produce no word_valid. The following frame is received normally.
